clint_timer: RTL and testbench



---
 rtl/clint_timer.sv | 167 ++++++++++++++++
 tb/tb_clint_timer.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/clint_timer.sv
// -----------------------------------------------------------------------------
// clint_timer
//
// Core-local interruptor. Holds the memory-mapped msip, mtimecmp and mtime
// registers behind a single-outstanding request/response bus. It also drives
// the level interrupt lines that the CSR block consumes.
//
// Register window (offsets from BASE, 64 KiB aligned):
//   0x0000 msip     : bit0 only. Other bits read 0 and ignore writes.
//   0xBFF8 mtime    : advances once every PRESCALE core cycles, wraps mod 2^64
//   0x4000 mtimecmp : timer compare value
//   anything else   : resp_err=1, read data 0, write has no effect
//
// Handshake:
//   A request is accepted when req_valid & req_ready, where
//   req_ready = ~resp_valid | resp_ready.
//   The response appears on the following cycle. It holds until the cycle
//   with resp_valid & resp_ready, and a new request may be accepted in that
//   same cycle.
//
// Ports:
//   clk, reset             core clock, async active-high reset
//   req_valid/req_ready    request handshake
//   req_addr/req_write     byte address (8-byte aligned) and direction
//   req_strobe/req_data    per-byte write enables and store data
//   resp_valid/resp_ready  response handshake
//   resp_data/resp_err     load data (0 for stores), unmapped-address flag
//   ext_irq_async          raw asynchronous external interrupt
//   trint/swint/exint      timer / software / synchronised external irq
// -----------------------------------------------------------------------------
module clint_timer #(
   parameter logic [63:0] BASE     = 64'h0000_0000_0200_0000,
   parameter int unsigned PRESCALE = 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [63:0] req_addr,
   input  logic        req_write,
   input  logic [7:0]  req_strobe,
   input  logic [63:0] req_data,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic [63:0] resp_data,
   output logic        resp_err,
   input  logic        ext_irq_async,
   output logic        trint,
   output logic        swint,
   output logic        exint
);

   localparam int unsigned   CW       = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(PRESCALE - 1);

   // Byte-lane merge used by the mtime and mtimecmp writes.
   function automatic logic [63:0] merge_bytes(input logic [63:0] old_v,
                                               input logic [63:0] new_v,
                                               input logic [7:0]  strb);
      logic [63:0] r;
      r = old_v;
      for (int i = 0; i < 8; i++) begin
         if (strb[i]) r[8*i +: 8] = new_v[8*i +: 8];
      end
      return r;
   endfunction

   logic [CW-1:0] cnt_q, cnt_d;
   logic [63:0]   mtime_q, mtime_d;
   logic [63:0]   mtimecmp_q, mtimecmp_d;
   logic          msip_q, msip_d;
   logic          resp_valid_q, resp_valid_d;
   logic [63:0]   resp_data_q, resp_data_d;
   logic          resp_err_q, resp_err_d;
   logic          trint_q, swint_q;
   logic          sync1_q, sync2_q;

   logic          in_window, sel_msip, sel_cmp, sel_time, hit;
   logic          accept, wr, tick;
   logic [63:0]   rdata;

   // Address decode: the upper bits select the window, and the low 16 bits
   // must match a register offset exactly.
   assign in_window = (req_addr[63:16] == BASE[63:16]);
   assign sel_msip  = in_window && (req_addr[15:0] == 16'h0000);
   assign sel_cmp   = in_window && (req_addr[15:0] == 16'h4000);
   assign sel_time  = in_window && (req_addr[15:0] == 16'hBFF8);
   assign hit       = sel_msip | sel_cmp | sel_time;

   assign req_ready = ~resp_valid_q | resp_ready;
   assign accept    = req_valid & req_ready;
   assign wr        = accept & req_write;
   assign tick      = (cnt_q == CNT_LAST);

   // Read mux sees register values before this cycle's increment.
   always_comb begin
      rdata = '0;
      if (sel_msip)      rdata = {63'd0, msip_q};
      else if (sel_cmp)  rdata = mtimecmp_q;
      else if (sel_time) rdata = mtime_q;
   end

   // Timer and register next state. A same-cycle mtime write is applied on
   // top of the incremented value, so unwritten lanes still advance.
   always_comb begin
      cnt_d      = tick ? '0 : cnt_q + CW'(1);
      mtime_d    = tick ? mtime_q + 64'd1 : mtime_q;
      mtimecmp_d = mtimecmp_q;
      msip_d     = msip_q;
      if (wr && sel_time) mtime_d    = merge_bytes(mtime_d, req_data, req_strobe);
      if (wr && sel_cmp)  mtimecmp_d = merge_bytes(mtimecmp_q, req_data, req_strobe);
      if (wr && sel_msip && req_strobe[0]) msip_d = req_data[0];
   end

   // Response register: load on accept, otherwise clear on retire and hold
   // while stalled.
   always_comb begin
      resp_valid_d = resp_valid_q;
      resp_data_d  = resp_data_q;
      resp_err_d   = resp_err_q;
      if (accept) begin
         resp_valid_d = 1'b1;
         resp_data_d  = req_write ? 64'd0 : rdata;
         resp_err_d   = ~hit;
      end else if (resp_ready) begin
         resp_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_q        <= '0;
         mtime_q      <= '0;
         mtimecmp_q   <= '1;
         msip_q       <= 1'b0;
         resp_valid_q <= 1'b0;
         resp_data_q  <= '0;
         resp_err_q   <= 1'b0;
         trint_q      <= 1'b0;
         swint_q      <= 1'b0;
         sync1_q      <= 1'b0;
         sync2_q      <= 1'b0;
      end else begin
         cnt_q        <= cnt_d;
         mtime_q      <= mtime_d;
         mtimecmp_q   <= mtimecmp_d;
         msip_q       <= msip_d;
         resp_valid_q <= resp_valid_d;
         resp_data_q  <= resp_data_d;
         resp_err_q   <= resp_err_d;
         // Interrupt lines are computed from the current register values,
         // so they trail the register state by one cycle.
         trint_q      <= (mtime_q >= mtimecmp_q);
         swint_q      <= msip_q;
         sync1_q      <= ext_irq_async;
         sync2_q      <= sync1_q;
      end
   end

   assign resp_valid = resp_valid_q;
   assign resp_data  = resp_data_q;
   assign resp_err   = resp_err_q;
   assign trint      = trint_q;
   assign swint      = swint_q;
   assign exint      = sync2_q;

endmodule

// File: tb/tb_clint_timer.sv
// -----------------------------------------------------------------------------
// tb_clint_timer
//
// Directed bench for clint_timer. A behavioural model of the register file
// and bus runs alongside the DUT and is compared on every falling edge.
// Hand-computed literal expectations pin the model at key points.
// Inputs change 1 time unit after a rising edge, and every task starts and
// ends at that offset.
// -----------------------------------------------------------------------------
module tb_clint_timer;

   localparam logic [63:0] BASE     = 64'h0000_0000_0200_0000;
   localparam int          PRESCALE = 1;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic [63:0] req_addr = '0;
   logic        req_write = 1'b0;
   logic [7:0]  req_strobe = '0;
   logic [63:0] req_data = '0;
   logic        resp_valid;
   logic        resp_ready = 1'b1;
   logic [63:0] resp_data;
   logic        resp_err;
   logic        ext_irq_async = 1'b0;
   logic        trint, swint, exint;

   int checks = 0;
   int errors = 0;

   clint_timer #(.BASE(BASE), .PRESCALE(PRESCALE)) dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_addr(req_addr), .req_write(req_write),
      .req_strobe(req_strobe), .req_data(req_data),
      .resp_valid(resp_valid), .resp_ready(resp_ready),
      .resp_data(resp_data), .resp_err(resp_err),
      .ext_irq_async(ext_irq_async),
      .trint(trint), .swint(swint), .exint(exint)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   logic [63:0] m_time, m_cmp, m_rdata;
   logic        m_msip, m_trint, m_swint, m_s1, m_s2, m_rv, m_rerr;
   int          m_cnt;

   // 0=msip, 1=mtimecmp, 2=mtime, -1=unmapped
   function automatic int reg_index(input logic [63:0] addr);
      logic [63:0] off;
      off = addr - BASE;
      if (off == 64'h0)    return 0;
      if (off == 64'h4000) return 1;
      if (off == 64'hBFF8) return 2;
      return -1;
   endfunction

   function automatic logic [63:0] lane_write(input logic [63:0] old_v,
                                              input logic [63:0] d,
                                              input logic [7:0]  s);
      logic [63:0] r;
      r = old_v;
      for (int i = 0; i < 8; i++) if (s[i]) r[8*i +: 8] = d[8*i +: 8];
      return r;
   endfunction

   task automatic model_step();
      logic [63:0] nt, rd;
      logic        tr, sw, acc;
      int          idx;
      if (reset) begin
         m_time = 0; m_cmp = '1; m_msip = 0; m_cnt = 0;
         m_trint = 0; m_swint = 0; m_s1 = 0; m_s2 = 0;
         m_rv = 0; m_rdata = 0; m_rerr = 0;
      end else begin
         acc = req_valid && (!m_rv || resp_ready);
         tr  = (m_time >= m_cmp);
         sw  = m_msip;
         nt  = m_time;
         if (m_cnt == PRESCALE - 1) begin
            nt = m_time + 64'd1;
            m_cnt = 0;
         end else begin
            m_cnt++;
         end
         if (acc) begin
            idx = reg_index(req_addr);
            rd  = (idx == 0) ? {63'd0, m_msip} : (idx == 1) ? m_cmp : (idx == 2) ? m_time : 64'd0;
            m_rv = 1; m_rerr = (idx < 0); m_rdata = req_write ? 64'd0 : rd;
            if (req_write) begin
               if (idx == 0 && req_strobe[0]) m_msip = req_data[0];
               if (idx == 1) m_cmp = lane_write(m_cmp, req_data, req_strobe);
               if (idx == 2) nt = lane_write(nt, req_data, req_strobe);
            end
         end else if (resp_ready) begin
            m_rv = 0;
         end
         m_time = nt; m_trint = tr; m_swint = sw;
         m_s2 = m_s1; m_s1 = ext_irq_async;
      end
   endtask

   always @(posedge clk or posedge reset) model_step();

   // ---------------- every-cycle compare ----------------
   always @(negedge clk) begin
      if (!reset) begin
         chk("req_ready", req_ready, !m_rv || resp_ready);
         chk("resp_valid", resp_valid, m_rv);
         if (m_rv) begin
            chk("resp_data", resp_data, m_rdata);
            chk("resp_err", resp_err, m_rerr);
         end
         chk("trint", trint, m_trint);
         chk("swint", swint, m_swint);
         chk("exint", exint, m_s2);
      end
   end

   // ---------------- driver tasks ----------------
   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic bus(input logic w, input logic [63:0] addr, input logic [7:0] strb,
                      input logic [63:0] d, output logic [63:0] rdata, output logic err);
      int n;
      req_valid = 1; req_write = w; req_addr = addr; req_strobe = strb; req_data = d;
      n = 0;
      @(negedge clk);
      while (!req_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("accept_timeout", (n < 20), 1);
      @(posedge clk);
      #1 req_valid = 0; req_write = 0; req_strobe = 0; req_data = 0;
      @(negedge clk);
      rdata = resp_data;
      err   = resp_err;
      @(posedge clk);
      #1;
   endtask

   // ---------------- directed stimulus ----------------
   logic [63:0] rd;
   logic        er;
   int          n;

   initial begin
      #1 reset = 1;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_resp_valid", resp_valid, 0);
      chk("rst_req_ready", req_ready, 1);
      chk("rst_trint", trint, 0);
      chk("rst_swint", swint, 0);
      chk("rst_exint", exint, 0);
      reset = 0;

      // 1: free-running mtime, compare at all-ones
      idle(10);
      bus(0, BASE + 64'hBFF8, 8'h00, 64'd0, rd, er);
      chk("t1_mtime", rd, 64'd10);
      chk("t1_err", er, 0);
      bus(0, BASE + 64'h4000, 8'h00, 64'd0, rd, er);
      chk("t1_cmp_reset", rd, 64'hFFFF_FFFF_FFFF_FFFF);
      chk("t1_trint", trint, 0);

      // 2: timer interrupt rise and fall
      bus(1, BASE + 64'h4000, 8'hFF, 64'd20, rd, er);
      chk("t2_store_data", rd, 64'd0);
      n = 0;
      while (!trint && n < 100) begin
         @(posedge clk);
         #1;
         n++;
      end
      chk("t2_trint_rise", (n < 100), 1);
      bus(0, BASE + 64'hBFF8, 8'h00, 64'd0, rd, er);
      chk("t2_mtime_at_rise", rd, 64'd21);
      bus(1, BASE + 64'h4000, 8'hFF, 64'd1000, rd, er);
      chk("t2_trint_fall", trint, 0);

      // 3: software interrupt
      bus(1, BASE, 8'hFF, 64'h0000_0000_FFFF_FFFF, rd, er);
      chk("t3_swint_set", swint, 1);
      bus(0, BASE, 8'h00, 64'd0, rd, er);
      chk("t3_msip_read", rd, 64'd1);
      bus(1, BASE, 8'hFF, 64'd0, rd, er);
      chk("t3_swint_clr", swint, 0);

      // 4: mtime wrap, then partial-lane writes racing the tick
      bus(1, BASE + 64'hBFF8, 8'hFF, 64'hFFFF_FFFF_FFFF_FFFE, rd, er);
      bus(0, BASE + 64'hBFF8, 8'h00, 64'd0, rd, er);
      chk("t4_mtime_ff", rd, 64'hFFFF_FFFF_FFFF_FFFF);
      bus(0, BASE + 64'hBFF8, 8'h00, 64'd0, rd, er);
      chk("t4_mtime_wrap", rd, 64'd1);
      chk("t4_err", er, 0);
      bus(1, BASE + 64'hBFF8, 8'h01, 64'hDEAD_BEEF_0000_00AB, rd, er);
      bus(1, BASE + 64'h4000, 8'h0F, 64'h1111_2222_3333_4444, rd, er);
      idle(3);

      // 5: response stall, back-to-back accept, unmapped addresses
      bus(1, BASE + 64'h4000, 8'hFF, 64'h1234_5678_9ABC_DEF0, rd, er);
      bus(1, BASE, 8'h01, 64'd1, rd, er);
      resp_ready = 0;
      req_valid = 1; req_write = 0; req_addr = BASE + 64'h4000;
      @(posedge clk);
      #1 req_addr = BASE;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("t5_stall_ready", req_ready, 0);
         chk("t5_stall_data", resp_data, 64'h1234_5678_9ABC_DEF0);
         @(posedge clk);
         #1;
      end
      resp_ready = 1;
      @(negedge clk);
      chk("t5_ready_on_retire", req_ready, 1);
      @(posedge clk);
      #1 req_valid = 0;
      chk("t5_b2b_valid", resp_valid, 1);
      chk("t5_b2b_data", resp_data, 64'd1);
      idle(1);
      bus(0, BASE + 64'h100, 8'h00, 64'd0, rd, er);
      chk("t5_err_flag", er, 1);
      chk("t5_err_data", rd, 64'd0);
      bus(1, BASE + 64'h108, 8'hFF, 64'hFFFF, rd, er);
      chk("t5_err_store", er, 1);
      bus(0, BASE + 64'h1_BFF8, 8'h00, 64'd0, rd, er);
      chk("t5_err_window", er, 1);

      // 6: external interrupt sync, then reset mid-response
      ext_irq_async = 1;
      chk("t6_exint_0", exint, 0);
      idle(1);
      chk("t6_exint_1", exint, 0);
      idle(1);
      chk("t6_exint_2", exint, 1);
      bus(1, BASE + 64'h4000, 8'hFF, 64'd0, rd, er);
      chk("t6_trint_pre", trint, 1);
      resp_ready = 0;
      req_valid = 1; req_addr = BASE + 64'hBFF8;
      @(posedge clk);
      #1 req_valid = 0;
      #2;
      chk("t6_pre_valid", resp_valid, 1);
      chk("t6_pre_swint", swint, 1);
      reset = 1;
      #1;
      chk("t6_rst_valid", resp_valid, 0);
      chk("t6_rst_data", resp_data, 64'd0);
      chk("t6_rst_trint", trint, 0);
      chk("t6_rst_swint", swint, 0);
      chk("t6_rst_exint", exint, 0);
      chk("t6_rst_ready", req_ready, 1);
      @(posedge clk);
      #1 reset = 0; resp_ready = 1; ext_irq_async = 0;
      idle(5);
      bus(0, BASE + 64'hBFF8, 8'h00, 64'd0, rd, er);
      chk("t6_mtime_after_rst", rd, 64'd5);
      idle(3);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      errors++;
      $display("FAIL watchdog: got timeout expected finish");
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $fatal(1, "watchdog");
   end

endmodule
